// File: rtl/pipelined_controlunit_if.sv
// Bus bundle between the RV32I datapath and the pipelined control unit.
// The slave modport is the control unit's view; master is the datapath/testbench view.
interface pipelined_controlunit_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic [DATA_WIDTH-1:0]     Instr_i;
    logic                      ZeroE_i;
    logic                      LtSE_i;
    logic                      LtUE_i;
    logic [2:0]                ImmSrcD_o;
    logic                      IllegalD_o;
    logic [3:0]                ALUCtrlE_o;
    logic [1:0]                ALUSrcAE_o;
    logic                      ALUSrcBE_o;
    logic                      PCSrcE_o;
    logic                      JumpRegE_o;
    logic [1:0]                ForwardAE_o;
    logic [1:0]                ForwardBE_o;
    logic                      MemWriteM_o;
    logic [1:0]                MemTypeM_o;
    logic                      MemSignM_o;
    logic                      RegWriteW_o;
    logic [1:0]                ResultSrcW_o;
    logic [REG_ADDR_WIDTH-1:0] RdW_o;
    logic                      StallF_o;
    logic                      StallD_o;
    logic                      FlushD_o;

    modport slave (
        input  Instr_i, ZeroE_i, LtSE_i, LtUE_i,
        output ImmSrcD_o, IllegalD_o, ALUCtrlE_o, ALUSrcAE_o, ALUSrcBE_o, PCSrcE_o,
               JumpRegE_o, ForwardAE_o, ForwardBE_o, MemWriteM_o, MemTypeM_o,
               MemSignM_o, RegWriteW_o, ResultSrcW_o, RdW_o, StallF_o, StallD_o, FlushD_o
    );

    modport master (
        output Instr_i, ZeroE_i, LtSE_i, LtUE_i,
        input  ImmSrcD_o, IllegalD_o, ALUCtrlE_o, ALUSrcAE_o, ALUSrcBE_o, PCSrcE_o,
               JumpRegE_o, ForwardAE_o, ForwardBE_o, MemWriteM_o, MemTypeM_o,
               MemSignM_o, RegWriteW_o, ResultSrcW_o, RdW_o, StallF_o, StallD_o, FlushD_o
    );
endinterface

// File: rtl/pipelined_controlunit.sv
// RV32I pipelined control unit: decode in D, control word carried through E/M/W,
// branch/jump resolution in E and load-use stall, redirect flush and EX forwarding.
module pipelined_controlunit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input logic clk_i,
    input logic rst_i,
    pipelined_controlunit_if.slave bus
);
    typedef struct packed {
        logic                      reg_write;
        logic                      mem_write;
        logic                      branch;
        logic                      jump;
        logic                      jump_reg;
        logic [3:0]                alu_ctrl;
        logic [1:0]                alu_src_a;
        logic                      alu_src_b;
        logic [1:0]                result_src;
        logic [1:0]                mem_type;
        logic                      mem_sign;
        logic [2:0]                funct3;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
    } ex_t;

    typedef struct packed {
        logic                      reg_write;
        logic                      mem_write;
        logic [1:0]                result_src;
        logic [1:0]                mem_type;
        logic                      mem_sign;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } mem_t;

    typedef struct packed {
        logic                      reg_write;
        logic [1:0]                result_src;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } wb_t;

    logic [DATA_WIDTH-1:0] instr;
    logic                  unused_instr_bits;
    ex_t                   ctrl_d, id_ex;
    mem_t                  ex_mem;
    wb_t                   mem_wb;
    logic [2:0]            imm_src_d;
    logic                  illegal_d, reads_rs1, reads_rs2, mem_ok;
    logic [1:0]            mem_type_d;
    logic                  mem_sign_d;
    logic                  cond_e, pcsrc_e, load_use, stall;

    assign instr             = bus.Instr_i;
    assign unused_instr_bits = ^{instr[31], instr[29:25]};

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_op = alt ? 4'b0001 : 4'b0000;
            3'b001:  alu_op = 4'b1000;
            3'b010:  alu_op = 4'b0101;
            3'b011:  alu_op = 4'b0110;
            3'b100:  alu_op = 4'b0100;
            3'b101:  alu_op = alt ? 4'b1001 : 4'b0111;
            3'b110:  alu_op = 4'b0011;
            default: alu_op = 4'b0010;
        endcase
    endfunction

    always_comb begin
        mem_ok     = 1'b1;
        mem_type_d = 2'b00;
        mem_sign_d = 1'b0;
        case (instr[14:12])
            3'b000:  mem_type_d = 2'b01;
            3'b001:  mem_type_d = 2'b10;
            3'b010:  mem_type_d = 2'b00;
            3'b100:  begin mem_type_d = 2'b01; mem_sign_d = 1'b1; end
            3'b101:  begin mem_type_d = 2'b10; mem_sign_d = 1'b1; end
            default: mem_ok = 1'b0;
        endcase
    end

    always_comb begin
        ctrl_d        = '0;
        ctrl_d.funct3 = instr[14:12];
        ctrl_d.rd     = instr[11:7];
        ctrl_d.rs1    = instr[19:15];
        ctrl_d.rs2    = instr[24:20];
        imm_src_d     = 3'b000;
        illegal_d     = 1'b0;
        reads_rs1     = 1'b0;
        reads_rs2     = 1'b0;
        case (instr[6:0])
            7'd3: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_src_b  = 1'b1;
                ctrl_d.result_src = 2'b01;
                ctrl_d.mem_type   = mem_type_d;
                ctrl_d.mem_sign   = mem_sign_d;
                reads_rs1         = 1'b1;
                illegal_d         = !mem_ok;
            end
            7'd19: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src_b = 1'b1;
                // Only shifts look at funct7; addi with imm[10] set must stay an add
                ctrl_d.alu_ctrl  = alu_op(instr[14:12], (instr[14:12] == 3'b101) && instr[30]);
                reads_rs1        = 1'b1;
            end
            7'd51: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_ctrl  = alu_op(instr[14:12], instr[30]);
                reads_rs1        = 1'b1;
                reads_rs2        = 1'b1;
            end
            7'd35: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src_b = 1'b1;
                ctrl_d.mem_type  = mem_type_d;
                ctrl_d.mem_sign  = mem_sign_d;
                imm_src_d        = 3'b001;
                reads_rs1        = 1'b1;
                reads_rs2        = 1'b1;
                illegal_d        = !mem_ok;
            end
            7'd99: begin
                ctrl_d.branch   = 1'b1;
                ctrl_d.alu_ctrl = 4'b0001;
                imm_src_d       = 3'b010;
                reads_rs1       = 1'b1;
                reads_rs2       = 1'b1;
                illegal_d       = (instr[14:13] == 2'b01);
            end
            7'd23: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src_a = 2'b01;
                ctrl_d.alu_src_b = 1'b1;
                imm_src_d        = 3'b011;
            end
            7'd55: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src_a = 2'b10;
                ctrl_d.alu_src_b = 1'b1;
                imm_src_d        = 3'b011;
            end
            7'd103: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.jump       = 1'b1;
                ctrl_d.jump_reg   = 1'b1;
                ctrl_d.alu_src_b  = 1'b1;
                ctrl_d.result_src = 2'b10;
                reads_rs1         = 1'b1;
            end
            7'd111: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.jump       = 1'b1;
                ctrl_d.alu_src_a  = 2'b01;
                ctrl_d.alu_src_b  = 1'b1;
                ctrl_d.result_src = 2'b10;
                imm_src_d         = 3'b100;
            end
            default: illegal_d = 1'b1;
        endcase
        if (illegal_d) begin
            ctrl_d    = '0;
            reads_rs1 = 1'b0;
            reads_rs2 = 1'b0;
        end
    end

    always_comb begin
        case (id_ex.funct3)
            3'b000:  cond_e = bus.ZeroE_i;
            3'b001:  cond_e = !bus.ZeroE_i;
            3'b100:  cond_e = bus.LtSE_i;
            3'b101:  cond_e = !bus.LtSE_i;
            3'b110:  cond_e = bus.LtUE_i;
            3'b111:  cond_e = !bus.LtUE_i;
            default: cond_e = 1'b0;
        endcase
    end

    assign pcsrc_e  = id_ex.jump || (id_ex.branch && cond_e);
    assign load_use = (id_ex.result_src == 2'b01) && (id_ex.rd != '0) &&
                      ((reads_rs1 && (id_ex.rd == ctrl_d.rs1)) ||
                       (reads_rs2 && (id_ex.rd == ctrl_d.rs2)));
    // A redirect discards the dependent D instruction anyway, so it wins over the stall
    assign stall    = load_use && !pcsrc_e;

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs, input mem_t m,
                                           input wb_t w);
        if (rs != '0 && m.reg_write && m.rd == rs)      fwd_sel = 2'b10;
        else if (rs != '0 && w.reg_write && w.rd == rs) fwd_sel = 2'b01;
        else                                            fwd_sel = 2'b00;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            id_ex  <= (pcsrc_e || stall) ? '0 : ctrl_d;
            ex_mem <= '{reg_write: id_ex.reg_write, mem_write: id_ex.mem_write,
                        result_src: id_ex.result_src, mem_type: id_ex.mem_type,
                        mem_sign: id_ex.mem_sign, rd: id_ex.rd};
            mem_wb <= '{reg_write: ex_mem.reg_write, result_src: ex_mem.result_src,
                        rd: ex_mem.rd};
        end
    end

    assign bus.ImmSrcD_o    = imm_src_d;
    assign bus.IllegalD_o   = illegal_d;
    assign bus.StallF_o     = stall;
    assign bus.StallD_o     = stall;
    assign bus.FlushD_o     = pcsrc_e;
    assign bus.ALUCtrlE_o   = id_ex.alu_ctrl;
    assign bus.ALUSrcAE_o   = id_ex.alu_src_a;
    assign bus.ALUSrcBE_o   = id_ex.alu_src_b;
    assign bus.PCSrcE_o     = pcsrc_e;
    assign bus.JumpRegE_o   = id_ex.jump_reg;
    assign bus.ForwardAE_o  = fwd_sel(id_ex.rs1, ex_mem, mem_wb);
    assign bus.ForwardBE_o  = fwd_sel(id_ex.rs2, ex_mem, mem_wb);
    assign bus.MemWriteM_o  = ex_mem.mem_write;
    assign bus.MemTypeM_o   = ex_mem.mem_type;
    assign bus.MemSignM_o   = ex_mem.mem_sign;
    assign bus.RegWriteW_o  = mem_wb.reg_write;
    assign bus.ResultSrcW_o = mem_wb.result_src;
    assign bus.RdW_o        = mem_wb.rd;
endmodule

// File: tb/tb_pipelined_controlunit.sv
// Directed bench for pipelined_controlunit: expectations are queued with the cycle they
// fall due when an instruction is driven, and checked mid-cycle when that cycle arrives.
module tb_pipelined_controlunit;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    pipelined_controlunit_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

    pipelined_controlunit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    localparam int S_ALUCTRL = 0, S_SRCA = 1, S_SRCB = 2, S_PCSRC = 3, S_JREG = 4,
                   S_FWDA = 5, S_FWDB = 6, S_MEMW = 7, S_MEMT = 8, S_MEMS = 9,
                   S_REGW = 10, S_RESW = 11, S_RDW = 12, S_STALLF = 13, S_STALLD = 14,
                   S_FLUSHD = 15, S_IMM = 16, S_ILL = 17;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        int         cyc;
        int         sel;
        logic [7:0] exp;
        string      tag;
    } item_t;

    item_t sb[$];
    int    cyc = 0;
    int    n_assert = 0;
    int    n_fail = 0;

    function automatic logic [7:0] sample(input int sel);
        case (sel)
            S_ALUCTRL: sample = 8'(bus.ALUCtrlE_o);
            S_SRCA:    sample = 8'(bus.ALUSrcAE_o);
            S_SRCB:    sample = 8'(bus.ALUSrcBE_o);
            S_PCSRC:   sample = 8'(bus.PCSrcE_o);
            S_JREG:    sample = 8'(bus.JumpRegE_o);
            S_FWDA:    sample = 8'(bus.ForwardAE_o);
            S_FWDB:    sample = 8'(bus.ForwardBE_o);
            S_MEMW:    sample = 8'(bus.MemWriteM_o);
            S_MEMT:    sample = 8'(bus.MemTypeM_o);
            S_MEMS:    sample = 8'(bus.MemSignM_o);
            S_REGW:    sample = 8'(bus.RegWriteW_o);
            S_RESW:    sample = 8'(bus.ResultSrcW_o);
            S_RDW:     sample = 8'(bus.RdW_o);
            S_STALLF:  sample = 8'(bus.StallF_o);
            S_STALLD:  sample = 8'(bus.StallD_o);
            S_FLUSHD:  sample = 8'(bus.FlushD_o);
            S_IMM:     sample = 8'(bus.ImmSrcD_o);
            default:   sample = 8'(bus.IllegalD_o);
        endcase
    endfunction

    task automatic push(input int off, input int sel, input logic [7:0] v, input string tag);
        item_t it;
        it.cyc = cyc + off;
        it.sel = sel;
        it.exp = v;
        it.tag = tag;
        sb.push_back(it);
    endtask

    task automatic tick();
        logic [7:0] obs;
        #4;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                obs = sample(sb[i].sel);
                n_assert++;
                assert (obs === sb[i].exp) else begin
                    n_fail++;
                    $error("FAIL %s @cycle %0d: observed %0h expected %0h",
                           sb[i].tag, cyc, obs, sb[i].exp);
                end
                sb.delete(i);
            end
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    initial begin
        bus.Instr_i = NOP;
        bus.ZeroE_i = 1'b0;
        bus.LtSE_i  = 1'b0;
        bus.LtUE_i  = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cyc   = 0;

        // c0: reset state, then add x3,x1,x2 enters D
        bus.Instr_i = 32'h002081B3;
        push(0, S_REGW, 0, "rst_regw");
        push(0, S_MEMW, 0, "rst_memw");
        push(0, S_PCSRC, 0, "rst_pcsrc");
        push(0, S_FWDA, 0, "rst_fwda");
        push(0, S_FWDB, 0, "rst_fwdb");
        push(0, S_STALLF, 0, "rst_stallf");
        push(0, S_FLUSHD, 0, "rst_flushd");
        push(0, S_RDW, 0, "rst_rdw");
        push(0, S_ALUCTRL, 0, "rst_aluctrl");
        push(1, S_ALUCTRL, 4'b0000, "add_aluctrl");
        push(1, S_SRCB, 0, "add_srcb");
        push(3, S_REGW, 1, "add_regw");
        push(3, S_RDW, 3, "add_rdw");
        push(3, S_RESW, 0, "add_resw");
        tick();
        // c1: addi x1,x0,5
        bus.Instr_i = 32'h00500093;
        push(0, S_IMM, 3'b000, "addi_imm");
        push(1, S_SRCB, 1, "addi_srcb");
        tick();
        // c2: add x2,x1,x1 -> forwards from M
        bus.Instr_i = 32'h00108133;
        push(1, S_FWDA, 2'b10, "fwd_m_a");
        push(1, S_FWDB, 2'b10, "fwd_m_b");
        tick();
        // c3..c5: addi, nop, add -> forwards from W
        bus.Instr_i = 32'h00500093;
        tick();
        bus.Instr_i = NOP;
        tick();
        bus.Instr_i = 32'h00108133;
        push(1, S_FWDA, 2'b01, "fwd_w_a");
        push(1, S_FWDB, 2'b01, "fwd_w_b");
        tick();
        // c6: sub x4,x1,x2
        bus.Instr_i = 32'h40208233;
        push(1, S_ALUCTRL, 4'b0001, "sub_aluctrl");
        push(1, S_FWDA, 2'b00, "sub_fwda");
        push(1, S_FWDB, 2'b10, "sub_fwdb");
        tick();
        // c7: srai x5,x5,3
        bus.Instr_i = 32'h4032D293;
        push(1, S_ALUCTRL, 4'b1001, "srai_aluctrl");
        tick();
        // c8: addi x6,x0,1024 (bit 30 set, must stay add)
        bus.Instr_i = 32'h40000313;
        push(1, S_ALUCTRL, 4'b0000, "addi_b30_aluctrl");
        tick();
        // c9: lw x5,0(x6)
        bus.Instr_i = 32'h00032283;
        push(2, S_MEMT, 2'b00, "lw_memt");
        push(2, S_MEMW, 0, "lw_memw");
        push(3, S_RESW, 2'b01, "lw_resw");
        push(3, S_RDW, 5, "lw_rdw");
        tick();
        // c10: sub x7,x5,x8 stalls one cycle, held in D for c11
        bus.Instr_i = 32'h408283B3;
        push(0, S_STALLF, 1, "lu_stallf");
        push(0, S_STALLD, 1, "lu_stalld");
        push(1, S_STALLF, 0, "lu_stallf_end");
        push(1, S_ALUCTRL, 4'b0000, "lu_bubble_alu");
        push(2, S_ALUCTRL, 4'b0001, "lu_sub_alu");
        push(2, S_FWDA, 2'b01, "lu_fwda");
        push(2, S_FWDB, 2'b00, "lu_fwdb");
        tick();
        tick();
        // c12: bge x1,x2,+8 taken (LtS=0)
        bus.Instr_i = 32'h0020D463;
        push(0, S_IMM, 3'b010, "bge_imm");
        push(1, S_PCSRC, 1, "bge_t_pcsrc");
        push(1, S_FLUSHD, 1, "bge_t_flushd");
        tick();
        // c13: addi x9 in D gets flushed
        bus.Instr_i = 32'h00100493;
        push(1, S_SRCB, 0, "flush_bubble_srcb");
        push(1, S_PCSRC, 0, "flush_bubble_pcsrc");
        push(2, S_MEMW, 0, "flush_bubble_memw");
        push(3, S_REGW, 0, "flush_bubble_regw");
        tick();
        // c14: bge not taken (LtS=1 during c15)
        bus.Instr_i = 32'h0020D463;
        push(1, S_PCSRC, 0, "bge_nt_pcsrc");
        push(1, S_FLUSHD, 0, "bge_nt_flushd");
        tick();
        bus.LtSE_i  = 1'b1;
        bus.Instr_i = 32'h00100493;
        push(3, S_REGW, 1, "addi9_regw");
        push(3, S_RDW, 9, "addi9_rdw");
        tick();
        bus.LtSE_i  = 1'b0;
        // c16: lbu x10,0(x1)
        bus.Instr_i = 32'h0000C503;
        push(2, S_MEMT, 2'b01, "lbu_memt");
        push(2, S_MEMS, 1, "lbu_mems");
        tick();
        // c17: sh x2,0(x1)
        bus.Instr_i = 32'h00209023;
        push(0, S_IMM, 3'b001, "sh_imm");
        push(2, S_MEMT, 2'b10, "sh_memt");
        push(2, S_MEMW, 1, "sh_memw");
        push(2, S_MEMS, 0, "sh_mems");
        tick();
        // c18: illegal opcode 0x7F
        bus.Instr_i = 32'h0000007F;
        push(0, S_ILL, 1, "ill_flag");
        push(2, S_MEMW, 0, "ill_memw");
        push(3, S_REGW, 0, "ill_regw");
        tick();
        // c19: jal x1,16
        bus.Instr_i = 32'h010000EF;
        push(0, S_IMM, 3'b100, "jal_imm");
        push(0, S_ILL, 0, "jal_legal");
        push(1, S_PCSRC, 1, "jal_pcsrc");
        push(1, S_JREG, 0, "jal_jreg");
        push(1, S_FLUSHD, 1, "jal_flushd");
        push(3, S_RESW, 2'b10, "jal_resw");
        push(3, S_RDW, 1, "jal_rdw");
        tick();
        bus.Instr_i = NOP;
        tick();
        // c21: jalr x0,0(x1)
        bus.Instr_i = 32'h00008067;
        push(1, S_PCSRC, 1, "jalr_pcsrc");
        push(1, S_JREG, 1, "jalr_jreg");
        tick();
        bus.Instr_i = NOP;
        tick();
        // c23: sw x2,4(x1); reset pulsed while it sits in E (c24)
        bus.Instr_i = 32'h0020A223;
        tick();
        rst_i       = 1'b1;
        bus.Instr_i = NOP;
        push(1, S_MEMW, 0, "rst_sw_memw");
        push(1, S_REGW, 0, "rst_mid_regw");
        push(1, S_ALUCTRL, 0, "rst_mid_alu");
        push(1, S_SRCB, 0, "rst_mid_srcb");
        push(1, S_PCSRC, 0, "rst_mid_pcsrc");
        push(1, S_FWDA, 0, "rst_mid_fwda");
        push(1, S_STALLF, 0, "rst_mid_stallf");
        push(1, S_FLUSHD, 0, "rst_mid_flushd");
        tick();
        rst_i = 1'b0;
        // c25: addi x0,x0,7 then add x11,x0,x0: x0 is never forwarded
        bus.Instr_i = 32'h00700013;
        tick();
        bus.Instr_i = 32'h000005B3;
        push(1, S_FWDA, 2'b00, "x0_fwda");
        push(1, S_FWDB, 2'b00, "x0_fwdb");
        tick();
        // c27: lw x0 followed by a reader of x0: no stall
        bus.Instr_i = 32'h0000A003;
        tick();
        bus.Instr_i = 32'h00000633;
        push(0, S_STALLF, 0, "lw_x0_nostall");
        tick();
        // c29: lui / auipc operand A selects
        bus.Instr_i = 32'h000016B7;
        push(0, S_IMM, 3'b011, "lui_imm");
        push(1, S_SRCA, 2'b10, "lui_srca");
        tick();
        bus.Instr_i = 32'h00000717;
        push(1, S_SRCA, 2'b01, "auipc_srca");
        tick();
        bus.Instr_i = NOP;
        for (int k = 0; k < 4; k++) tick();

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
